ap_ctrl_sequencer: RTL and testbench

AP_CTRL_SEQUENCER -- requirements
Module: ap_ctrl_sequencer

---
 rtl/ap_seq_pkg.sv | 5 +
 rtl/ap_seq_sat_counter.sv | 16 +
 rtl/ap_ctrl_sequencer.sv | 75 +++++++
 tb/tb_ap_ctrl_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ap_seq_pkg.sv
// ap_seq_pkg: shared state type and default counter width for the ap_ctrl_hs sequencer
package ap_seq_pkg;
    localparam int CNT_W_DEFAULT = 32;
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_DONE, S_FINISH, S_TIMEOUT} state_t;
endpackage

// File: rtl/ap_seq_sat_counter.sv
// ap_seq_sat_counter: up-counter with synchronous load that sticks at all-ones
module ap_seq_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else if (load) count <= load_val;
        else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: issues NUM_TRANS ap_ctrl_hs transactions with watchdog and latency statistics
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int NUM_TRANS      = 1,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             finish,
    output logic             timeout,
    output logic             protocol_err,
    output logic             busy,
    output logic [CNT_W-1:0] trans_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] max_latency
);
    state_t           state, nxt;
    logic [CNT_W-1:0] lat, tc_next;
    logic             active, complete, last, lat_hit, lat_load;

    assign active   = state == S_START || state == S_WAIT_DONE;
    assign complete = (state == S_START && ap_ready && ap_done) || (state == S_WAIT_DONE && ap_done);
    assign tc_next  = &trans_count ? trans_count : trans_count + 1'b1;
    assign last     = tc_next == CNT_W'(NUM_TRANS);
    assign lat_hit  = lat == CNT_W'(TIMEOUT_CYCLES);
    // reload on every entry to START, including back-to-back restarts from START itself
    assign lat_load = nxt == S_START && (state != S_START || complete);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:               nxt = !enable ? S_IDLE : NUM_TRANS > 0 ? S_START : S_FINISH;
            S_START, S_WAIT_DONE: nxt = complete ? (last ? S_FINISH : S_START) :
                                        lat_hit ? S_TIMEOUT :
                                        (state == S_START && ap_ready) ? S_WAIT_DONE : state;
            default:              nxt = state;
        endcase
    end

    assign ap_start = state == S_START;
    assign busy     = active;
    assign finish   = state == S_FINISH || state == S_TIMEOUT;
    assign timeout  = state == S_TIMEOUT;

    ap_seq_sat_counter #(.W(CNT_W)) u_lat (
        .clock(clock), .reset(reset), .load(lat_load), .load_val(CNT_W'(1)),
        .inc(active), .count(lat)
    );

    ap_seq_sat_counter #(.W(CNT_W)) u_trans (
        .clock(clock), .reset(reset), .load(1'b0), .load_val('0),
        .inc(complete), .count(trans_count)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state        <= S_IDLE;
            protocol_err <= 1'b0;
            last_latency <= '0;
            max_latency  <= '0;
        end else begin
            state <= nxt;
            if (ap_done && !active) protocol_err <= 1'b1;
            if (complete) begin
                last_latency <= lat;
                if (lat > max_latency) max_latency <= lat;
            end
        end
endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// tb_ap_ctrl_sequencer: plan-driven checks of four sequencer configurations
module tb_ap_ctrl_sequencer;
    localparam int NT [4] = '{3, 2, 0, 4};
    localparam int TO [4] = '{10, 10, 10, 20};

    logic        clock = 1'b0;
    logic        reset [4], enable [4], ap_ready [4], ap_done [4];
    logic        ap_start [4], finish [4], timeout [4], protocol_err [4], busy [4];
    logic [31:0] trans_count [4], last_latency [4], max_latency [4];
    int          tests = 0, fails = 0;
    int          rdq[$], dnq[$];

    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            ap_ctrl_sequencer #(.NUM_TRANS(NT[g]), .TIMEOUT_CYCLES(TO[g]), .CNT_W(32)) u_dut (
                .clock(clock), .reset(reset[g]), .enable(enable[g]),
                .ap_start(ap_start[g]), .ap_ready(ap_ready[g]), .ap_done(ap_done[g]),
                .finish(finish[g]), .timeout(timeout[g]), .protocol_err(protocol_err[g]),
                .busy(busy[g]), .trans_count(trans_count[g]),
                .last_latency(last_latency[g]), .max_latency(max_latency[g])
            );
        end
    endgenerate

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int idx, input string tag);
        check1({tag, "_start"}, ap_start[idx], 1'b0);
        check1({tag, "_busy"}, busy[idx], 1'b0);
        check1({tag, "_finish"}, finish[idx], 1'b0);
        check1({tag, "_timeout"}, timeout[idx], 1'b0);
        check1({tag, "_perr"}, protocol_err[idx], 1'b0);
        check32({tag, "_tcount"}, trans_count[idx], 0);
        check32({tag, "_last"}, last_latency[idx], 0);
        check32({tag, "_max"}, max_latency[idx], 0);
    endtask

    task automatic do_reset(input int idx);
        reset[idx] = 1'b1; enable[idx] = 1'b0; ap_ready[idx] = 1'b0; ap_done[idx] = 1'b0;
        @(posedge clock); #1;
        reset[idx] = 1'b0;
    endtask

    task automatic plan_random(input int n, input int maxd);
        rdq.delete(); dnq.delete();
        for (int k = 0; k < n; k++) begin
            int r = $urandom_range(1, 4);
            rdq.push_back(r);
            dnq.push_back($urandom_range(r, maxd));
        end
    endtask

    // Each transaction of the plan lasts dnq[i] cycles; ready pulses at position rdq[i], done at dnq[i].
    task automatic run(input int idx, input int abort_c, input logic perr_exp);
        int nt = NT[idx], tmo = TO[idx];
        int i = 0, p = 1, c = 0, lastl = 0, maxl = 0;
        logic timed = 1'b0;
        enable[idx] = 1'b1;
        while (i < nt && !timed) begin
            @(posedge clock); #1; c++;
            if (c == 2) enable[idx] = 1'($urandom_range(0, 1));
            if (c == abort_c) begin
                reset[idx] = 1'b1; enable[idx] = 1'b0; ap_ready[idx] = 1'b0; ap_done[idx] = 1'b0;
                #1;
                check_zero(idx, "abort");
                @(posedge clock); #1;
                reset[idx] = 1'b0;
                return;
            end
            check1("start", ap_start[idx], p <= rdq[i]);
            check1("busy", busy[idx], 1'b1);
            check1("finish_early", finish[idx], 1'b0);
            check32("tcount_run", trans_count[idx], i);
            ap_ready[idx] = p == rdq[i];
            ap_done[idx]  = p == dnq[i];
            if (p == dnq[i]) begin
                lastl = p;
                if (p > maxl) maxl = p;
                i++; p = 1;
            end else if (p == tmo) timed = 1'b1;
            else p++;
        end
        @(posedge clock); #1;
        ap_ready[idx] = 1'b0; ap_done[idx] = 1'b0; enable[idx] = 1'b1;
        check1("finish", finish[idx], 1'b1);
        check1("timeout", timeout[idx], timed);
        check1("start_end", ap_start[idx], 1'b0);
        check1("busy_end", busy[idx], 1'b0);
        check1("perr_end", protocol_err[idx], perr_exp);
        check32("tcount", trans_count[idx], i);
        check32("last_lat", last_latency[idx], lastl);
        check32("max_lat", max_latency[idx], maxl);
        @(posedge clock); #1;
        check1("finish_hold", finish[idx], 1'b1);
        check1("start_hold", ap_start[idx], 1'b0);
        check32("tcount_hold", trans_count[idx], i);
        enable[idx] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            reset[k] = 1'b1; enable[k] = 1'b0; ap_ready[k] = 1'b0; ap_done[k] = 1'b0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) reset[k] = 1'b0;
        for (int k = 0; k < 4; k++) check_zero(k, "reset");

        rdq = '{2, 2, 2}; dnq = '{5, 5, 5};
        run(0, 0, 1'b0);
        do_reset(0);
        rdq = '{2}; dnq = '{1000};
        run(0, 0, 1'b0);
        do_reset(0);
        repeat (3) begin
            plan_random(3, 10);
            run(0, 0, 1'b0);
            do_reset(0);
        end

        rdq = '{1, 1}; dnq = '{1, 1};
        run(1, 0, 1'b0);

        rdq.delete(); dnq.delete();
        run(2, 0, 1'b0);

        ap_done[3] = 1'b1;
        @(posedge clock); #1;
        ap_done[3] = 1'b0;
        check1("idle_perr", protocol_err[3], 1'b1);
        check1("idle_busy", busy[3], 1'b0);
        @(posedge clock); #1;
        check1("idle_start", ap_start[3], 1'b0);
        plan_random(4, 8);
        run(3, 0, 1'b1);
        do_reset(3);

        rdq = '{2, 1, 3, 1}; dnq = '{4, 5, 3, 2};
        run(3, 4 + 3, 1'b0);
        run(3, 0, 1'b0);
        do_reset(3);
        repeat (2) begin
            plan_random(4, 20);
            run(3, 0, 1'b0);
            do_reset(3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
